fpu_op_queue: RTL and testbench
===============================

// Module: fpu_op_queue
// PURPOSE
//  Operation issue queue directly upstream of the bfloat16 fpu. Accepts {mode, in1, in2}
//  requests over a valid/ready handshake, buffers them in a small FIFO and presents the
//  oldest one to fpu mode_i/in1_i/in2_i. Decouples the producer from fpu/consumer stalls.
//  Also rejects non-one-hot modes before they reach the fpu.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  DATA_W  16  operand width (bfloat16)
// PORTS
//  clk           in   1       single clock, all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  push_valid_i  in   1       producer has a request
//  push_ready_o  out  1       queue can accept a request this cycle
//  push_mode_i   in   4       one-hot op: 0001 ADD, 0010 SUB, 0100 MUL, 1000 DIV
//  push_in1_i    in   DATA_W  operand A
//  push_in2_i    in   DATA_W  operand B
//  issue_valid_o out  1       head entry valid, drives fpu this cycle
//  issue_ready_i in   1       downstream consumes head this cycle
//  mode_o        out  4       to fpu mode_i
//  in1_o         out  DATA_W  to fpu in1_i
//  in2_o         out  DATA_W  to fpu in2_i
//  count_o       out  clog2(DEPTH)+1  valid entries held
//  err_o         out  1       one-cycle pulse: illegal mode was dropped
// BEHAVIOUR
//  - Reset (sync, rst=1 at posedge): wr/rd pointers 0, count_o 0, issue_valid_o 0,
//    err_o 0, mode_o 4'b0000, in1_o/in2_o 0. All buffered entries discarded; reset
//    mid-operation wins over any simultaneous push or pop.
//  - Pointers are clog2(DEPTH)+1 bits; full = MSBs differ and index bits equal, empty =
//    pointers equal. Index wraps DEPTH-1 -> 0 naturally.
//  - push_ready_o = !full, registered-state only; no combinational path from
//    issue_ready_i. Full queue with simultaneous pop still refuses the push.
//  - Push accepted when push_valid_i & push_ready_o. If push_mode_i is not one-hot
//    (incl. 0000): handshake completes, entry not written, err_o=1 on next cycle only.
//  - Pop when issue_valid_o & issue_ready_i; head advances, next entry visible the
//    following cycle.
//  - issue_valid_o = !empty. Show-ahead: head entry on mode_o/in1_o/in2_o while valid.
//    When empty, mode_o=4'b0000, in1_o=in2_o=0 (fpu idle, no stale op).
//  - Latency: push into empty queue -> issue_valid_o=1 with that entry on the next posedge.
//  - Simultaneous legal push and pop (not full): count_o unchanged, both pointers advance.
//    Empty queue: a pop cannot occur; same-cycle push is not bypassed.
//  - count_o: +1 legal push only, -1 pop only, unchanged both/neither; never exceeds DEPTH.
//  - Order strictly FIFO; entries are stored as-is (no operand modification).
// STRUCTURE
//  - Shared package fpu_pkg: MODE_ADD/SUB/MUL/DIV 4-bit constants, BF16_W=16,
//    op_req_t {mode[3:0], in1[15:0], in2[15:0]}; same constants used by fpu and benches.
//  - One sub-module: sync_fifo (parameterised width/depth, pointers, full/empty, count).
//    fpu_op_queue adds the mode legality filter, err_o, and idle-output zeroing.
// TESTING
//  1 Reset: rst=1 two cycles with push_valid_i=1 -> issue_valid_o=0, count_o=0,
//    mode_o=0000, push_ready_o=1 after release.
//  2 Single op: push {0001,3F80,4000}, issue_ready_i=1 -> next cycle issue_valid_o=1,
//    mode_o=0001, in1_o=3F80, in2_o=4000; following cycle empty, mode_o=0000.
//  3 Fill/full: issue_ready_i=0, push 5 ops (MUL 3F80*4000, ...) -> first 4 accepted,
//    count_o=4, push_ready_o=0 for 5th; then drain 4 in order 1st..4th, count_o 4->0.
//  4 Simultaneous: count_o=2, legal push and pop same cycle -> count_o stays 2, order kept;
//    pointer wrap exercised over >= 2*DEPTH pushes, no data corruption.
//  5 Illegal mode: push mode 0011 then 0000 -> both handshakes complete, err_o pulses
//    one cycle each, count_o unchanged, neither appears on mode_o.
//  6 Reset mid-op: count_o=3, rst=1 one cycle -> count_o=0, issue_valid_o=0 next cycle;
//    old entries never reissued.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and request type for the bfloat16 fpu and its issue queue.
package fpu_pkg;

  localparam int BF16_W = 16;

  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_SUB = 4'b0010;
  localparam logic [3:0] MODE_MUL = 4'b0100;
  localparam logic [3:0] MODE_DIV = 4'b1000;

  typedef struct packed {
    logic [3:0]        mode;
    logic [BF16_W-1:0] in1;
    logic [BF16_W-1:0] in2;
  } op_req_t;

  // A mode is legal only when exactly one op bit is set.
  function automatic logic is_one_hot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'b0001)) == 4'b0000);
  endfunction

endpackage

// File: rtl/fpu_op_queue_sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Status and head data derived from registered pointers only.
  always_comb begin
    full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty_o   = (wr_ptr_q == rd_ptr_q);
    count_o   = wr_ptr_q - rd_ptr_q;
    rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Next-state for storage and pointers; writes to a full or reads from an empty queue are ignored.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data_i;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= WIDTH'(0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fpu_op_queue.sv
// Issue queue in front of the bfloat16 fpu: filters illegal modes and idles the fpu
// inputs to zero whenever nothing is queued.
module fpu_op_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [3:0]               push_mode_i,
  input  logic [DATA_W-1:0]        push_in1_i,
  input  logic [DATA_W-1:0]        push_in2_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [3:0]               mode_o,
  output logic [DATA_W-1:0]        in1_o,
  output logic [DATA_W-1:0]        in2_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     err_o
);

  localparam int REQ_W = 4 + 2 * DATA_W;

  logic             full_s, empty_s;
  logic             push_fire_s, pop_fire_s, wr_en_s;
  logic [REQ_W-1:0] head_s;
  logic             err_d, err_q;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_s),
    .wr_data_i ({push_mode_i, push_in1_i, push_in2_i}),
    .rd_en_i   (pop_fire_s),
    .rd_data_o (head_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (count_o)
  );

  // Handshakes; an illegal mode still completes its handshake but is never stored.
  always_comb begin
    push_ready_o  = !full_s;
    issue_valid_o = !empty_s;
    push_fire_s   = push_valid_i && push_ready_o;
    pop_fire_s    = issue_valid_o && issue_ready_i;
    wr_en_s       = push_fire_s && is_one_hot(push_mode_i);
    err_d         = push_fire_s && !is_one_hot(push_mode_i);
  end

  // Head presentation, forced to zero while empty so the fpu never sees a stale op.
  always_comb begin
    if (issue_valid_o) begin
      mode_o = head_s[REQ_W-1 -: 4];
      in1_o  = head_s[2*DATA_W-1 -: DATA_W];
      in2_o  = head_s[DATA_W-1:0];
    end else begin
      mode_o = 4'b0000;
      in1_o  = DATA_W'(0);
      in2_o  = DATA_W'(0);
    end
  end

  // Dropped-request pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_fpu_op_queue.sv
// Directed bench for fpu_op_queue with a reference queue of expected issued ops.
module tb_fpu_op_queue;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [3:0]  push_mode_i;
  logic [15:0] push_in1_i, push_in2_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [3:0]  mode_o;
  logic [15:0] in1_o, in2_o;
  logic [2:0]  count_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  op_req_t sb[$];
  logic exp_err = 1'b0;

  always #5 clk = ~clk;

  fpu_op_queue #(.DEPTH(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_mode_i(push_mode_i), .push_in1_i(push_in1_i), .push_in2_i(push_in2_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .mode_o(mode_o), .in1_o(in1_o), .in2_o(in2_o),
    .count_o(count_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare outputs against the model, update the model, advance.
  task automatic cyc(input logic pv, input logic [3:0] m, input logic [15:0] a,
                     input logic [15:0] b, input logic ir, input string tag);
    logic    push_ok, pop_ok, legal, nxt_err;
    op_req_t head;
    push_valid_i  = pv;
    push_mode_i   = m;
    push_in1_i    = a;
    push_in2_i    = b;
    issue_ready_i = ir;
    #1;
    chk({tag, ".count"}, 36'(count_o), 36'(sb.size()));
    chk({tag, ".valid"}, 36'(issue_valid_o), 36'(sb.size() != 0));
    chk({tag, ".ready"}, 36'(push_ready_o), 36'(sb.size() != 4));
    chk({tag, ".err"},   36'(err_o), 36'(exp_err));
    if (sb.size() != 0) head = sb[0];
    else head = '{mode: 4'b0000, in1: 16'h0000, in2: 16'h0000};
    chk({tag, ".head"}, {mode_o, in1_o, in2_o}, head);
    legal   = ($countones(m) == 1);
    push_ok = pv && (sb.size() != 4);
    pop_ok  = ir && (sb.size() != 0);
    nxt_err = push_ok && !legal;
    if (pop_ok) void'(sb.pop_front());
    if (push_ok && legal) sb.push_back('{mode: m, in1: a, in2: b});
    @(posedge clk);
    #1;
    exp_err = nxt_err;
  endtask

  task automatic do_reset(input int n);
    rst           = 1'b1;
    push_valid_i  = 1'b1;
    push_mode_i   = MODE_ADD;
    push_in1_i    = 16'h1234;
    push_in2_i    = 16'h5678;
    issue_ready_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    // 1: reset held with a push pending
    do_reset(2);
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b0, "rst");

    // 2: single op through an idle queue
    cyc(1'b1, MODE_ADD, 16'h3F80, 16'h4000, 1'b1, "single_push");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "single_issue");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "single_idle");

    // 3: fill past capacity with consumer stalled, then drain in order
    cyc(1'b1, MODE_MUL, 16'h3F80, 16'h4000, 1'b0, "fill1");
    cyc(1'b1, MODE_SUB, 16'h4040, 16'h3F00, 1'b0, "fill2");
    cyc(1'b1, MODE_DIV, 16'h4100, 16'h4080, 1'b0, "fill3");
    cyc(1'b1, MODE_ADD, 16'hC000, 16'h3E80, 1'b0, "fill4");
    cyc(1'b1, MODE_MUL, 16'hDEAD, 16'hBEEF, 1'b0, "fill5_refused");
    cyc(1'b1, MODE_MUL, 16'hDEAD, 16'hBEEF, 1'b1, "full_pop_push_refused");
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "drain");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "drained");

    // 4: steady state at two entries with simultaneous push/pop, wrapping the pointers
    cyc(1'b1, MODE_ADD, 16'h0101, 16'h0202, 1'b0, "pre1");
    cyc(1'b1, MODE_SUB, 16'h0303, 16'h0404, 1'b0, "pre2");
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      cyc(1'b1, 4'(4'b0001 << (i % 4)), ra, rb, 1'b1, "simul");
    end
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "simul_drain1");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "simul_drain2");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "simul_empty");

    // 5: illegal modes dropped around a legal one
    cyc(1'b1, MODE_DIV, 16'h4000, 16'h4000, 1'b0, "legal_before");
    cyc(1'b1, 4'b0011, 16'hAAAA, 16'h5555, 1'b0, "illegal_0011");
    cyc(1'b1, 4'b0000, 16'hBBBB, 16'h6666, 1'b0, "illegal_0000");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "err_second");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "err_clear");

    // 6: reset with three entries queued
    cyc(1'b1, MODE_ADD, 16'h1111, 16'h2222, 1'b0, "mid1");
    cyc(1'b1, MODE_SUB, 16'h3333, 16'h4444, 1'b0, "mid2");
    cyc(1'b1, MODE_MUL, 16'h5555, 16'h6666, 1'b0, "mid3");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b0, "mid_held");
    do_reset(1);
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "post_rst");
    cyc(1'b1, MODE_DIV, 16'h7777, 16'h8888, 1'b1, "post_rst_push");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "post_rst_issue");
    cyc(1'b0, 4'b0000, 16'h0, 16'h0, 1'b1, "post_rst_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
